nvdla_glb_csb_scratch: RTL and testbench



---
 rtl/nvdla_glb_csb_scratch.sv | 156 +++++++++++++++
 tb/tb_nvdla_glb_csb_scratch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_glb_csb_scratch.sv
// CSB debug endpoint for the GLB partition: ID register, saturating error counter and
// NREG byte-enabled scratch registers, answered through a fixed-depth response pipeline.
module nvdla_glb_csb_scratch #(
    parameter int unsigned NREG      = 8,
    parameter logic [21:0] BASE_ADDR = 22'h0,
    parameter int unsigned RESP_LAT  = 1,
    parameter logic [31:0] ID_VALUE  = 32'h0000_0001,
    parameter logic [31:0] RST_VAL   = 32'h0
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        csb2gec_req_pvld,
    output logic        csb2gec_req_prdy,
    input  logic [62:0] csb2gec_req_pd,
    output logic        gec2csb_resp_valid,
    output logic [33:0] gec2csb_resp_pd,
    output logic        err_pulse
);

    if (NREG < 1 || NREG > 64 || RESP_LAT < 1 || RESP_LAT > 4) begin : gen_param_check
        $error("nvdla_glb_csb_scratch: NREG or RESP_LAT out of range");
    end

    logic [21:0] req_addr;
    logic [21:0] req_off;
    logic [21:0] scr_idx;
    logic [31:0] req_wdat;
    logic        req_write;
    logic        req_nposted;
    logic [3:0]  req_wrbe;
    logic        unused_req_bits;

    assign req_addr        = csb2gec_req_pd[21:0];
    assign req_wdat        = csb2gec_req_pd[53:22];
    assign req_write       = csb2gec_req_pd[54];
    assign req_nposted     = csb2gec_req_pd[55];
    assign req_wrbe        = csb2gec_req_pd[60:57];
    assign unused_req_bits = ^{csb2gec_req_pd[62:61], csb2gec_req_pd[56]};

    assign csb2gec_req_prdy = 1'b1;

    // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
    assign req_off = req_addr - BASE_ADDR;
    assign scr_idx = req_off - 22'd2;

    logic hit_id;
    logic hit_err;
    logic hit_scr;
    logic req_err;

    assign hit_id  = (req_off == 22'd0);
    assign hit_err = (req_off == 22'd1);
    assign hit_scr = (req_off >= 22'd2) && (req_off <= 22'(NREG + 1));
    assign req_err = req_write ? !(hit_err || hit_scr)
                               : !(hit_id || hit_err || hit_scr);

    logic [31:0] scratch_q [NREG];
    logic [31:0] err_cnt_q;
    logic [31:0] err_cnt_d;
    logic        err_pulse_q;
    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'h0;
        if (hit_id) begin
            rd_data = ID_VALUE;
        end else if (hit_err) begin
            rd_data = err_cnt_q;
        end else if (hit_scr) begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (scr_idx == 22'(i)) begin
                    rd_data = scratch_q[i];
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                scratch_q[i] <= RST_VAL;
            end
        end else if (csb2gec_req_pvld && req_write && hit_scr) begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (scr_idx == 22'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_wrbe[b]) begin
                            scratch_q[i][8*b +: 8] <= req_wdat[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // A write to ERR_CNT is never an error, so increment and clear are exclusive.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (csb2gec_req_pvld && req_err && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end else if (csb2gec_req_pvld && req_write && hit_err && (req_wrbe != 4'h0)) begin
            err_cnt_d = 32'h0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err_cnt_q   <= 32'h0;
            err_pulse_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= csb2gec_req_pvld && req_err;
        end
    end

    assign err_pulse = err_pulse_q;

    logic        resp_gen;
    logic [33:0] resp_new;

    assign resp_gen = csb2gec_req_pvld && (!req_write || req_nposted);
    assign resp_new = {req_write, req_err, req_write ? 32'h0 : rd_data};

    logic [RESP_LAT-1:0] vld_q;
    logic [33:0]         pd_q [RESP_LAT];

    // Payload stages load only behind a valid entry so the last stage holds the previous response.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_q <= '0;
            for (int k = 0; k < int'(RESP_LAT); k++) begin
                pd_q[k] <= 34'h0;
            end
        end else begin
            vld_q[0] <= resp_gen;
            if (resp_gen) begin
                pd_q[0] <= resp_new;
            end
            for (int k = 1; k < int'(RESP_LAT); k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    pd_q[k] <= pd_q[k-1];
                end
            end
        end
    end

    assign gec2csb_resp_valid = vld_q[RESP_LAT-1];
    assign gec2csb_resp_pd    = pd_q[RESP_LAT-1];

`ifdef ASSERT_ON
    a_resp_valid_known: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !$isunknown(gec2csb_resp_valid));
`endif

endmodule

// File: tb/tb_nvdla_glb_csb_scratch.sv
// Scoreboard bench: three endpoints (latency 1, 3, 4) see identical directed CSB traffic;
// expected responses are queued at issue and matched by one negedge monitor.
module tb_nvdla_glb_csb_scratch;

    localparam logic [21:0] BASE = 22'h100;
    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{1, 3, 4};

    typedef struct {
        logic [33:0] pd;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_pvld = 1'b0;
    logic [62:0] req_pd = '0;
    logic        stim_err = 1'b0;
    logic        err_exp;
    int          cyc = 0;

    logic        prdy       [NDUT];
    logic        resp_valid [NDUT];
    logic [33:0] resp_pd    [NDUT];
    logic        errp       [NDUT];

    exp_t exp_q [$];
    int   ptr [NDUT] = '{0, 0, 0};
    int   flush_base = 0;
    bit   check_end = 1'b0;
    bit   end_done = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        nvdla_glb_csb_scratch #(
            .NREG(8), .BASE_ADDR(BASE), .RESP_LAT(LATS[g]),
            .ID_VALUE(32'h0000_0001), .RST_VAL(32'h0)
        ) u_dut (
            .nvdla_core_clk    (clk),
            .nvdla_core_rstn   (rstn),
            .csb2gec_req_pvld  (req_pvld),
            .csb2gec_req_prdy  (prdy[g]),
            .csb2gec_req_pd    (req_pd),
            .gec2csb_resp_valid(resp_valid[g]),
            .gec2csb_resp_pd   (resp_pd[g]),
            .err_pulse         (errp[g])
        );
    end

    // Expected err_pulse: the hand-computed error flag of the request accepted at the last edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) err_exp <= 1'b0;
        else       err_exp <= req_pvld & stim_err;
    end

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < NDUT; g++) begin
            if (ptr[g] < flush_base) ptr[g] = flush_base;
            if (!rstn) begin
                total++;
                if (resp_valid[g] !== 1'b0 || resp_pd[g] !== 34'h0 || errp[g] !== 1'b0 || prdy[g] !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_state dut%0d: valid=%b pd=%h err=%b prdy=%b, required 0/0/0/1",
                             g, resp_valid[g], resp_pd[g], errp[g], prdy[g]);
                end
            end else begin
                if (resp_valid[g] === 1'b1) begin
                    total++;
                    if (ptr[g] >= exp_q.size()) begin
                        bad++;
                        $display("FAIL unexpected_resp dut%0d cyc=%0d: pd=%h, required no response", g, cyc, resp_pd[g]);
                    end else begin
                        e = exp_q[ptr[g]];
                        ptr[g]++;
                        if (resp_pd[g] !== e.pd || cyc != e.acc + LATS[g] - 1) begin
                            bad++;
                            $display("FAIL resp dut%0d: pd=%h at cyc %0d, required pd=%h at cyc %0d",
                                     g, resp_pd[g], cyc, e.pd, e.acc + LATS[g] - 1);
                        end
                    end
                end else if (resp_valid[g] !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL valid_known dut%0d: valid=%b, required 0 or 1", g, resp_valid[g]);
                end else if (ptr[g] < exp_q.size() && cyc > exp_q[ptr[g]].acc + LATS[g] - 1) begin
                    total++;
                    bad++;
                    $display("FAIL missing_resp dut%0d cyc=%0d: no response, required pd=%h",
                             g, cyc, exp_q[ptr[g]].pd);
                    ptr[g]++;
                end
                total++;
                if (errp[g] !== err_exp) begin
                    bad++;
                    $display("FAIL err_pulse dut%0d cyc=%0d: got %b, required %b", g, cyc, errp[g], err_exp);
                end
            end
            if (check_end && !end_done) begin
                total++;
                if (ptr[g] != exp_q.size()) begin
                    bad++;
                    $display("FAIL drain dut%0d: consumed %0d, required %0d", g, ptr[g], exp_q.size());
                end
            end
        end
        if (check_end) end_done = 1'b1;
    end

    task automatic drive(input logic [21:0] off, input logic [31:0] wdat, input logic wr, input logic np,
                         input logic [3:0] be, input logic [31:0] exp_rdat, input logic exp_err);
        exp_t e;
        logic [21:0] addr;
        @(negedge clk);
        addr     = BASE + off;
        req_pvld = 1'b1;
        req_pd   = {2'b00, be, 1'b0, np, wr, wdat, addr};
        stim_err = exp_err;
        if (!wr || np) begin
            e.pd  = {wr, exp_err, wr ? 32'h0 : exp_rdat};
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic rd(input logic [21:0] off, input logic [31:0] exp_rdat, input logic exp_err);
        drive(off, 32'h0, 1'b0, 1'b0, 4'h0, exp_rdat, exp_err);
    endtask

    task automatic wr(input logic [21:0] off, input logic [31:0] wdat, input logic np,
                      input logic [3:0] be, input logic exp_err);
        drive(off, wdat, 1'b1, np, be, 32'h0, exp_err);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_pvld = 1'b0;
            stim_err = 1'b0;
        end
    endtask

    initial begin
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle(2);

        rd(22'd0, 32'h0000_0001, 1'b0);
        wr(22'd2, 32'hA5A5_1234, 1'b1, 4'b0101, 1'b0);
        rd(22'd2, 32'h00A5_0034, 1'b0);
        idle(1);
        wr(22'd10, 32'hDEAD_BEEF, 1'b0, 4'hF, 1'b1);
        rd(22'd1, 32'd1, 1'b0);
        wr(22'd0, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1);
        rd(22'd1, 32'd2, 1'b0);
        rd(22'd10, 32'h0, 1'b1);
        rd(22'h3F_FFFF, 32'h0, 1'b1);
        wr(22'd9, 32'h1111_2222, 1'b0, 4'hF, 1'b0);
        rd(22'd9, 32'h1111_2222, 1'b0);
        rd(22'd10, 32'h0, 1'b1);
        rd(22'd1, 32'd5, 1'b0);
        wr(22'd1, 32'h0000_1234, 1'b1, 4'hF, 1'b0);
        rd(22'd1, 32'd0, 1'b0);
        rd(22'd100, 32'h0, 1'b1);
        wr(22'd1, 32'h0, 1'b1, 4'h0, 1'b0);
        rd(22'd1, 32'd1, 1'b0);
        wr(22'd3, 32'h9999_9999, 1'b1, 4'h0, 1'b0);
        rd(22'd3, 32'h0, 1'b0);
        idle(2);

        wr(22'd2, 32'h2222_2222, 1'b0, 4'hF, 1'b0);
        wr(22'd3, 32'h3333_3333, 1'b0, 4'hF, 1'b0);
        wr(22'd4, 32'h4444_4444, 1'b0, 4'hF, 1'b0);
        wr(22'd5, 32'h5555_5555, 1'b0, 4'hF, 1'b0);
        rd(22'd2, 32'h2222_2222, 1'b0);
        rd(22'd3, 32'h3333_3333, 1'b0);
        rd(22'd4, 32'h4444_4444, 1'b0);
        rd(22'd5, 32'h5555_5555, 1'b0);
        idle(6);

        force gen_dut[0].u_dut.err_cnt_q = 32'hFFFF_FFFE;
        force gen_dut[1].u_dut.err_cnt_q = 32'hFFFF_FFFE;
        force gen_dut[2].u_dut.err_cnt_q = 32'hFFFF_FFFE;
        #1;
        release gen_dut[0].u_dut.err_cnt_q;
        release gen_dut[1].u_dut.err_cnt_q;
        release gen_dut[2].u_dut.err_cnt_q;
        rd(22'd50, 32'h0, 1'b1);
        rd(22'd50, 32'h0, 1'b1);
        rd(22'd1, 32'hFFFF_FFFF, 1'b0);
        idle(6);

        rd(22'd2, 32'h2222_2222, 1'b0);
        @(posedge clk);
        #1 req_pvld = 1'b0;
        stim_err = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b0;
        flush_base = exp_q.size();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle(6);
        rd(22'd2, 32'h0, 1'b0);
        rd(22'd9, 32'h0, 1'b0);
        rd(22'd1, 32'h0, 1'b0);
        rd(22'd0, 32'h0000_0001, 1'b0);
        idle(8);

        check_end = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
